// File: rtl/as_lut_access_arbiter_if.sv
// Bus bundle between the LUT access arbiter and its environment:
// lookup requesters, register block and the shared CAM-LUT.
interface as_lut_access_arbiter_if #(
    parameter int NUM_REQ           = 4,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_IQ_BITS       = 3,
    parameter int LUT_DEPTH_BITS    = 4
);
    localparam int KEY_W = 160 + NUM_IQ_BITS;
    localparam int WR_W  = 1 + NUM_OUTPUT_QUEUES + 48;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*KEY_W-1:0]     req_key;
    logic [NUM_REQ-1:0]           resp_ack;
    logic [NUM_OUTPUT_QUEUES-1:0] resp_dst_ports;
    logic                         resp_timeout;

    logic                         lut_lookup_req;
    logic [KEY_W-1:0]             lut_key;
    logic [NUM_OUTPUT_QUEUES-1:0] lut_dst_ports;
    logic                         lut_lookup_ack;

    logic                         reg_rd_req;
    logic [LUT_DEPTH_BITS-1:0]    reg_rd_addr;
    logic                         reg_rd_ack;
    logic                         reg_wr_req;
    logic [LUT_DEPTH_BITS-1:0]    reg_wr_addr;
    logic [WR_W-1:0]              reg_wr_data;
    logic                         reg_wr_ack;

    logic                         lut_rd_req;
    logic [LUT_DEPTH_BITS-1:0]    lut_rd_addr;
    logic                         lut_rd_ack;
    logic                         lut_wr_req;
    logic [LUT_DEPTH_BITS-1:0]    lut_wr_addr;
    logic [WR_W-1:0]              lut_wr_data;
    logic                         lut_wr_ack;

    logic [15:0]                  timeout_count;

    // Arbiter side.
    modport slave (
        input  req_valid, req_key, lut_dst_ports, lut_lookup_ack,
               reg_rd_req, reg_rd_addr, reg_wr_req, reg_wr_addr, reg_wr_data,
               lut_rd_ack, lut_wr_ack,
        output resp_ack, resp_dst_ports, resp_timeout, lut_lookup_req, lut_key,
               reg_rd_ack, reg_wr_ack, lut_rd_req, lut_rd_addr,
               lut_wr_req, lut_wr_addr, lut_wr_data, timeout_count
    );

    // Environment side (requesters, register block, LUT).
    modport master (
        output req_valid, req_key, lut_dst_ports, lut_lookup_ack,
               reg_rd_req, reg_rd_addr, reg_wr_req, reg_wr_addr, reg_wr_data,
               lut_rd_ack, lut_wr_ack,
        input  resp_ack, resp_dst_ports, resp_timeout, lut_lookup_req, lut_key,
               reg_rd_ack, reg_wr_ack, lut_rd_req, lut_rd_addr,
               lut_wr_req, lut_wr_addr, lut_wr_data, timeout_count
    );
endinterface

// File: rtl/as_lut_access_arbiter.sv
// Serialises round-robin lookups and register read/write accesses onto one
// anti-spoof CAM-LUT, with a per-lookup timeout watchdog.
module as_lut_access_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_IQ_BITS       = 3,
    parameter int LUT_DEPTH_BITS    = 4,
    parameter int TIMEOUT           = 64
) (
    input  logic clk,
    input  logic reset,
    as_lut_access_arbiter_if.slave bus
);
    localparam int          KEY_W  = 160 + NUM_IQ_BITS;
    localparam int          NOQ    = NUM_OUTPUT_QUEUES;
    localparam int          WR_W   = 1 + NOQ + 48;
    localparam int          IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          TMR_W  = $clog2(TIMEOUT) + 1;
    localparam int unsigned NREQ_U = NUM_REQ;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RELEASE,
        ST_REG_RD,
        ST_REG_WR
    } state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_rr;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_last_was_reg;
    logic [TMR_W-1:0]          r_timer;
    logic [KEY_W-1:0]          r_key;
    logic                      r_lookup_req;
    logic [NUM_REQ-1:0]        r_resp_ack;
    logic [NOQ-1:0]            r_resp_dst;
    logic                      r_resp_timeout;
    logic [15:0]               r_timeout_count;
    logic [LUT_DEPTH_BITS-1:0] r_rd_addr;
    logic [LUT_DEPTH_BITS-1:0] r_wr_addr;
    logic [WR_W-1:0]           r_wr_data;

    logic                      w_lookup_pend;
    logic                      w_reg_pend;
    logic                      w_grant_found;
    logic [IDX_W-1:0]          w_grant_idx;
    logic [KEY_W-1:0]          w_grant_key;
    logic [NUM_REQ-1:0]        w_idx_onehot;

    assign w_lookup_pend = |bus.req_valid;
    assign w_reg_pend    = bus.reg_rd_req | bus.reg_wr_req;

    // First requester at or after the rr pointer, wrapping.
    always_comb begin : rr_pick
        logic [IDX_W-1:0] j;
        j             = '0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            j = IDX_W'((32'(r_rr) + k) % NREQ_U);
            if (!w_grant_found && bus.req_valid[j]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = j;
            end
        end
    end

    assign w_grant_key = bus.req_key[w_grant_idx*KEY_W +: KEY_W];

    always_comb begin
        w_idx_onehot        = '0;
        w_idx_onehot[r_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_rr            <= '0;
            r_idx           <= '0;
            r_last_was_reg  <= 1'b0;
            r_timer         <= '0;
            r_key           <= '0;
            r_lookup_req    <= 1'b0;
            r_resp_ack      <= '0;
            r_resp_dst      <= '0;
            r_resp_timeout  <= 1'b0;
            r_timeout_count <= '0;
            r_rd_addr       <= '0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
        end else begin
            r_resp_ack     <= '0;
            r_resp_timeout <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // Register side wins unless it also won the previous grant.
                    if (w_reg_pend && (!w_lookup_pend || !r_last_was_reg)) begin
                        r_last_was_reg <= 1'b1;
                        if (bus.reg_wr_req) begin
                            r_wr_addr <= bus.reg_wr_addr;
                            r_wr_data <= bus.reg_wr_data;
                            r_state   <= ST_REG_WR;
                        end else begin
                            r_rd_addr <= bus.reg_rd_addr;
                            r_state   <= ST_REG_RD;
                        end
                    end else if (w_grant_found) begin
                        r_idx          <= w_grant_idx;
                        r_key          <= w_grant_key;
                        r_rr           <= (w_grant_idx == IDX_LAST) ? '0 : w_grant_idx + 1'b1;
                        r_lookup_req   <= 1'b1;
                        r_timer        <= '0;
                        r_last_was_reg <= 1'b0;
                        r_state        <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (bus.lut_lookup_ack) begin
                        r_resp_dst   <= bus.lut_dst_ports;
                        r_resp_ack   <= w_idx_onehot;
                        r_lookup_req <= 1'b0;
                        r_state      <= ST_RELEASE;
                    end else if (r_timer == TMR_LAST) begin
                        r_resp_dst     <= '0;
                        r_resp_ack     <= w_idx_onehot;
                        r_resp_timeout <= 1'b1;
                        if (r_timeout_count != '1) begin
                            r_timeout_count <= r_timeout_count + 16'd1;
                        end
                        r_lookup_req   <= 1'b0;
                        r_state        <= ST_RELEASE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!bus.lut_lookup_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REG_RD: begin
                    if (bus.lut_rd_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REG_WR: begin
                    if (bus.lut_wr_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes drop combinationally on the ack so the LUT cannot accept twice.
    assign bus.lut_rd_req     = (r_state == ST_REG_RD) & ~bus.lut_rd_ack;
    assign bus.lut_wr_req     = (r_state == ST_REG_WR) & ~bus.lut_wr_ack;
    assign bus.reg_rd_ack     = (r_state == ST_REG_RD) &  bus.lut_rd_ack;
    assign bus.reg_wr_ack     = (r_state == ST_REG_WR) &  bus.lut_wr_ack;

    assign bus.lut_rd_addr    = r_rd_addr;
    assign bus.lut_wr_addr    = r_wr_addr;
    assign bus.lut_wr_data    = r_wr_data;
    assign bus.lut_lookup_req = r_lookup_req;
    assign bus.lut_key        = r_key;
    assign bus.resp_ack       = r_resp_ack;
    assign bus.resp_dst_ports = r_resp_dst;
    assign bus.resp_timeout   = r_resp_timeout;
    assign bus.timeout_count  = r_timeout_count;

endmodule

// File: tb/tb_as_lut_access_arbiter.sv
// Scoreboard bench for as_lut_access_arbiter: requester, register-block and
// LUT behaviour modelled around the DUT, lookup responses checked in order.
module tb_as_lut_access_arbiter;
    localparam int NREQ  = 4;
    localparam int NOQ   = 8;
    localparam int IQB   = 3;
    localparam int LDB   = 4;
    localparam int TMO   = 64;
    localparam int KEY_W = 160 + IQB;
    localparam int WR_W  = 1 + NOQ + 48;

    logic clk;
    logic reset;

    as_lut_access_arbiter_if #(
        .NUM_REQ(NREQ), .NUM_OUTPUT_QUEUES(NOQ), .NUM_IQ_BITS(IQB), .LUT_DEPTH_BITS(LDB)
    ) bus ();

    as_lut_access_arbiter #(
        .NUM_REQ(NREQ), .NUM_OUTPUT_QUEUES(NOQ), .NUM_IQ_BITS(IQB),
        .LUT_DEPTH_BITS(LDB), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int unsigned    idx;
        logic [NOQ-1:0] dst;
        bit             to;
    } exp_t;

    exp_t            sb[$];
    int              ev_q[$];          // 1 = lookup grant, 2 = register write grant
    logic [KEY_W-1:0] keys [NREQ];
    logic [NOQ-1:0]  lut_tbl [8];
    logic [WR_W-1:0] lut_mem [16];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    // Written by the main thread only.
    int unsigned arm_cnt [NREQ];
    bit          lk_en;
    bit          late_mode;
    // Written by the environment process only.
    int unsigned done_cnt [NREQ];
    int unsigned rise_cyc [NREQ];
    int unsigned resp_cyc;
    int unsigned rd_ack_cnt, wr_ack_cnt, reg_rd_ack_cnt, reg_wr_ack_cnt;
    int unsigned rd_overlap, wr_overlap, hold_viol;
    logic [LDB-1:0]   rd_addr_cap;
    logic [KEY_W-1:0] lk_key_cap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic push_exp(input int unsigned idx, input bit to);
        exp_t e;
        e.idx = idx;
        e.to  = to;
        e.dst = to ? '0 : lut_tbl[idx];
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            tick();
            ok = 1'b1;
            for (int i = 0; i < NREQ; i++) if (done_cnt[i] != arm_cnt[i]) ok = 1'b0;
        end
        check_eq(tag, ok, 1);
    endtask

    task automatic reg_write(input logic [LDB-1:0] a, input logic [WR_W-1:0] d);
        int unsigned base = reg_wr_ack_cnt;
        bit got = 1'b0;
        bus.reg_wr_req  = 1'b1;
        bus.reg_wr_addr = a;
        bus.reg_wr_data = d;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            got = (reg_wr_ack_cnt != base);
        end
        check_eq("wr_ack_wait", got, 1);
        bus.reg_wr_req = 1'b0;
    endtask

    task automatic reg_read(input logic [LDB-1:0] a);
        int unsigned base = reg_rd_ack_cnt;
        bit got = 1'b0;
        bus.reg_rd_req  = 1'b1;
        bus.reg_rd_addr = a;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            got = (reg_rd_ack_cnt != base);
        end
        check_eq("rd_ack_wait", got, 1);
        bus.reg_rd_req = 1'b0;
    endtask

    // Environment: requesters, LUT lookup/read/write responders, monitor.
    initial begin : env
        bit rd_seen, wr_seen, lk_seen, prev_lk, prev_wr;
        int unsigned late_hold;
        exp_t e;
        rd_seen = 0; wr_seen = 0; lk_seen = 0; prev_lk = 0; prev_wr = 0; late_hold = 0;
        resp_cyc = 0; rd_ack_cnt = 0; wr_ack_cnt = 0; reg_rd_ack_cnt = 0; reg_wr_ack_cnt = 0;
        rd_overlap = 0; wr_overlap = 0; hold_viol = 0; rd_addr_cap = '0; lk_key_cap = '0;
        for (int i = 0; i < NREQ; i++) begin done_cnt[i] = 0; rise_cyc[i] = 0; end
        bus.req_valid      = '0;
        bus.lut_lookup_ack = 1'b0;
        bus.lut_dst_ports  = '0;
        bus.lut_rd_ack     = 1'b0;
        bus.lut_wr_ack     = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.resp_ack != '0) begin
                resp_cyc = cyc;
                if (sb.size() == 0) begin
                    check_eq("resp_unexpected", bus.resp_ack, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("resp_ack", bus.resp_ack, 256'(1) << e.idx);
                    check_eq("resp_dst", bus.resp_dst_ports, e.dst);
                    check_eq("resp_timeout", bus.resp_timeout, e.to);
                    if (!e.to) check_eq("lut_key", lk_key_cap, keys[e.idx]);
                end
                for (int i = 0; i < NREQ; i++) if (bus.resp_ack[i]) done_cnt[i]++;
                if (bus.resp_timeout && late_mode) late_hold = 4;
            end
            if (bus.lut_lookup_req && !prev_lk) ev_q.push_back(1);
            if (late_hold > 0 && bus.lut_lookup_req) hold_viol++;
            prev_lk = bus.lut_lookup_req;

            if (late_hold > 0) begin
                bus.lut_lookup_ack = 1'b1;
                late_hold--;
                lk_seen = 1'b0;
            end else if (bus.lut_lookup_req) begin
                if (lk_seen && lk_en) begin
                    bus.lut_lookup_ack = 1'b1;
                    bus.lut_dst_ports  = lut_tbl[bus.lut_key[2:0]];
                    lk_key_cap         = bus.lut_key;
                end
                lk_seen = 1'b1;
            end else begin
                bus.lut_lookup_ack = 1'b0;
                lk_seen            = 1'b0;
            end

            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && arm_cnt[i] != done_cnt[i]) rise_cyc[i] = cyc;
                bus.req_valid[i] = (arm_cnt[i] != done_cnt[i]);
            end

            if (bus.lut_rd_ack) bus.lut_rd_ack = 1'b0;
            else if (bus.lut_rd_req) begin
                if (rd_seen) begin
                    bus.lut_rd_ack = 1'b1;
                    rd_ack_cnt++;
                    rd_addr_cap = bus.lut_rd_addr;
                    rd_seen = 1'b0;
                end else rd_seen = 1'b1;
            end else rd_seen = 1'b0;

            if (bus.lut_wr_ack) bus.lut_wr_ack = 1'b0;
            else if (bus.lut_wr_req) begin
                if (wr_seen) begin
                    bus.lut_wr_ack = 1'b1;
                    wr_ack_cnt++;
                    lut_mem[bus.lut_wr_addr] = bus.lut_wr_data;
                    wr_seen = 1'b0;
                end else wr_seen = 1'b1;
            end else wr_seen = 1'b0;

            #1;
            if (bus.reg_rd_ack) reg_rd_ack_cnt++;
            if (bus.reg_wr_ack) reg_wr_ack_cnt++;
            if (bus.lut_rd_req && bus.lut_rd_ack) rd_overlap++;
            if (bus.lut_wr_req && bus.lut_wr_ack) wr_overlap++;
            if (bus.lut_wr_req && !prev_wr) ev_q.push_back(2);
            prev_wr = bus.lut_wr_req;
        end
    end

    initial begin : main
        int unsigned b_rw, b_lw, b_rr, b_lr, ev_base;
        int fair_seq [4];
        fair_seq = '{2, 1, 2, 1};
        reset = 1'b1;
        lk_en = 1'b1;
        late_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) arm_cnt[i] = 0;
        lut_tbl = '{8'h11, 8'h54, 8'hA3, 8'h3C, 8'h0F, 8'hF0, 8'h5A, 8'hC3};
        bus.reg_rd_req  = 1'b0;
        bus.reg_rd_addr = '0;
        bus.reg_wr_req  = 1'b0;
        bus.reg_wr_addr = '0;
        bus.reg_wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            keys[i] = {32'($urandom), 32'($urandom), 16'($urandom), 32'($urandom),
                       16'($urandom), 32'($urandom), 3'(i)};
            bus.req_key[i*KEY_W +: KEY_W] = keys[i];
        end
        repeat (3) tick();

        check_eq("rst_resp_ack", bus.resp_ack, 0);
        check_eq("rst_lookup_req", bus.lut_lookup_req, 0);
        check_eq("rst_lut_key", bus.lut_key, 0);
        check_eq("rst_dst", bus.resp_dst_ports, 0);
        check_eq("rst_to_cnt", bus.timeout_count, 0);
        check_eq("rst_rd_req", bus.lut_rd_req, 0);
        check_eq("rst_wr_req", bus.lut_wr_req, 0);
        reset = 1'b0;
        tick();

        // Round-robin, two full rounds from pointer 0.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) push_exp(i, 0);
            for (int i = 0; i < NREQ; i++) arm_cnt[i]++;
            wait_idle("rr_wait");
        end

        // Single lookup from requester 1.
        push_exp(1, 0);
        arm_cnt[1]++;
        wait_idle("single_wait");
        check_eq("single_latency", resp_cyc - rise_cyc[1], 3);
        check_eq("single_dst_held", bus.resp_dst_ports, 8'h54);

        // Register write vs lookup alternation.
        b_rw = reg_wr_ack_cnt; b_lw = wr_ack_cnt; ev_base = ev_q.size();
        push_exp(2, 0);
        push_exp(2, 0);
        arm_cnt[2] += 2;
        tick();
        reg_write(4'd3, {1'b1, 8'h55, 48'h0123_4567_89AB});
        reg_write(4'd7, {1'b0, 8'hA0, 48'hFEDC_BA98_7654});
        wait_idle("fair_wait");
        repeat (2) tick();
        check_eq("fair_reg_wr_acks", reg_wr_ack_cnt - b_rw, 2);
        check_eq("fair_lut_wr_acks", wr_ack_cnt - b_lw, 2);
        check_eq("fair_wr_overlap", wr_overlap, 0);
        check_eq("fair_mem3", lut_mem[3], {1'b1, 8'h55, 48'h0123_4567_89AB});
        check_eq("fair_mem7", lut_mem[7], {1'b0, 8'hA0, 48'hFEDC_BA98_7654});
        check_eq("fair_ev_count", ev_q.size() - ev_base, 4);
        for (int k = 0; k < 4; k++) begin
            if (ev_base + k < ev_q.size())
                check_eq($sformatf("fair_order%0d", k), ev_q[ev_base + k], fair_seq[k]);
        end

        // Register read with ack gating.
        b_rr = reg_rd_ack_cnt; b_lr = rd_ack_cnt;
        reg_read(4'd5);
        repeat (3) tick();
        check_eq("rd_lut_acks", rd_ack_cnt - b_lr, 1);
        check_eq("rd_reg_acks", reg_rd_ack_cnt - b_rr, 1);
        check_eq("rd_overlap", rd_overlap, 0);
        check_eq("rd_addr", rd_addr_cap, 5);

        // Timeout, then a late ack held through RELEASE.
        lk_en = 1'b0;
        late_mode = 1'b1;
        push_exp(0, 1);
        arm_cnt[0]++;
        wait_idle("to_wait");
        check_eq("to_latency", resp_cyc - rise_cyc[0], TMO + 1);
        check_eq("to_count", bus.timeout_count, 1);
        check_eq("to_dst_held", bus.resp_dst_ports, 0);
        lk_en = 1'b1;
        late_mode = 1'b0;
        push_exp(3, 0);
        arm_cnt[3]++;
        wait_idle("after_to_wait");
        check_eq("release_hold", hold_viol, 0);
        check_eq("to_count_kept", bus.timeout_count, 1);

        // Reset in the middle of a lookup.
        lk_en = 1'b0;
        push_exp(1, 0);
        arm_cnt[1]++;
        repeat (6) tick();
        check_eq("mid_lookup_req", bus.lut_lookup_req, 1);
        reset = 1'b1;
        repeat (2) tick();
        check_eq("mid_rst_lookup_req", bus.lut_lookup_req, 0);
        check_eq("mid_rst_lut_key", bus.lut_key, 0);
        check_eq("mid_rst_dst", bus.resp_dst_ports, 0);
        check_eq("mid_rst_to_cnt", bus.timeout_count, 0);
        check_eq("mid_rst_resp_ack", bus.resp_ack, 0);
        reset = 1'b0;
        lk_en = 1'b1;
        wait_idle("regrant_wait");

        check_eq("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
